// File: rtl/crc16_frame_checker.sv
// Receive-side frame checker: hunts for a sync byte, forwards the payload and checks its CRC-16-CCITT.
// Optional CRC_STATS_EN adds ok_cnt and sync_drop_cnt counters.
module crc16_frame_checker #(
   parameter int          FRAME_LEN = 9,
   parameter logic [7:0]  SYNC_BYTE = 8'h7E,
   parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic [7:0]  dout,
   output logic        dout_valid,
   output logic        sof,
   output logic        frame_done,
   output logic        crc_ok,
   output logic [15:0] crc_calc,
   output logic [7:0]  err_cnt,
   output logic [2:0]  dbg_state
`ifdef CRC_STATS_EN
   ,
   output logic [15:0] ok_cnt,
   output logic [15:0] sync_drop_cnt
`endif
);

   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_PAYLOAD = 3'd1,
      S_CRC_HI  = 3'd2,
      S_CRC_LO  = 3'd3,
      S_CHECK   = 3'd4
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

   state_t      state_q, state_d;
   logic [15:0] crc_q, crc_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  rx_hi_q, rx_hi_d;
   logic [7:0]  dout_q, dout_d;
   logic        dout_valid_q, dout_valid_d;
   logic        sof_q, sof_d;
   logic        frame_done_q, frame_done_d;
   logic        crc_ok_q, crc_ok_d;
   logic [15:0] crc_calc_q, crc_calc_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        crc_match;
`ifdef CRC_STATS_EN
   logic [15:0] ok_cnt_q, ok_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

   // One byte, MSB first, poly 0x1021: the 8 bit-steps unrolled.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         if (r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else       r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      idx_d        = idx_q;
      rx_hi_d      = rx_hi_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      sof_d        = 1'b0;
      frame_done_d = 1'b0;
      crc_ok_d     = crc_ok_q;
      crc_calc_d   = crc_calc_q;
      err_cnt_d    = err_cnt_q;
      crc_match    = (crc_q == {rx_hi_q, din});
`ifdef CRC_STATS_EN
      ok_cnt_d     = ok_cnt_q;
      drop_cnt_d   = drop_cnt_q;
`endif
      case (state_q)
         S_HUNT: begin
            if (din_valid) begin
               if (din == SYNC_BYTE) begin
                  state_d = S_PAYLOAD;
                  crc_d   = CRC_INIT;
                  idx_d   = 8'd0;
               end
`ifdef CRC_STATS_EN
               else begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
               end
`endif
            end
         end
         S_PAYLOAD: begin
            if (din_valid) begin
               dout_d       = din;
               dout_valid_d = 1'b1;
               sof_d        = (idx_q == 8'd0);
               crc_d        = crc_step(crc_q, din);
               idx_d        = idx_q + 8'd1;
               if (idx_q == LAST_IDX) state_d = S_CRC_HI;
            end
         end
         S_CRC_HI: begin
            if (din_valid) begin
               rx_hi_d = din;
               state_d = S_CRC_LO;
            end
         end
         S_CRC_LO: begin
            // The verdict is registered on the CRC_LO sample so that it is
            // visible during the CHECK cycle, one cycle after the last byte.
            if (din_valid) begin
               frame_done_d = 1'b1;
               crc_ok_d     = crc_match;
               crc_calc_d   = crc_q;
               if (!crc_match && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
`ifdef CRC_STATS_EN
               if (crc_match) ok_cnt_d = ok_cnt_q + 16'd1;
`endif
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d = S_HUNT;
         end
         default: begin
            state_d = S_HUNT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_HUNT;
         crc_q        <= CRC_INIT;
         idx_q        <= 8'd0;
         rx_hi_q      <= 8'd0;
         dout_q       <= 8'd0;
         dout_valid_q <= 1'b0;
         sof_q        <= 1'b0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         crc_calc_q   <= 16'd0;
         err_cnt_q    <= 8'd0;
`ifdef CRC_STATS_EN
         ok_cnt_q     <= 16'd0;
         drop_cnt_q   <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         idx_q        <= idx_d;
         rx_hi_q      <= rx_hi_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sof_q        <= sof_d;
         frame_done_q <= frame_done_d;
         crc_ok_q     <= crc_ok_d;
         crc_calc_q   <= crc_calc_d;
         err_cnt_q    <= err_cnt_d;
`ifdef CRC_STATS_EN
         ok_cnt_q     <= ok_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign sof        = sof_q;
   assign frame_done = frame_done_q;
   assign crc_ok     = crc_ok_q;
   assign crc_calc   = crc_calc_q;
   assign err_cnt    = err_cnt_q;
   assign dbg_state  = state_q;
`ifdef CRC_STATS_EN
   assign ok_cnt        = ok_cnt_q;
   assign sync_drop_cnt = drop_cnt_q;
`endif

endmodule
